// File: rtl/neuron_activation.sv
// Neuron activation stage: signed 2*DATA_WIDTH accumulator -> DATA_WIDTH output via sigmoid ROM, ReLU or truncation.
// One-cycle registered latency, one sample per cycle, no backpressure; ACT_SIG_HALF_ROM_EN adds the symmetric half-table ROM.
module neuron_activation #(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 1,
    parameter int SIG_IN_WIDTH     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [1:0]                act_sel,
    input  logic [2*DATA_WIDTH-1:0]   sum,
    output logic [DATA_WIDTH-1:0]     out,
    output logic                      out_valid
);

    localparam int S      = 2*DATA_WIDTH-1;
    localparam int TOP    = S - WEIGHT_INT_WIDTH;
    localparam int FULL_N = 1 << SIG_IN_WIDTH;
    localparam int HALF_N = 1 << (SIG_IN_WIDTH-1);

    localparam logic [DATA_WIDTH-1:0]   HALF_SCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]   POS_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [SIG_IN_WIDTH-1:0] X_MAX      = {1'b0, {(SIG_IN_WIDTH-1){1'b1}}};
    localparam logic [SIG_IN_WIDTH-1:0] X_MIN      = {1'b1, {(SIG_IN_WIDTH-1){1'b0}}};

    // Piecewise-linear sigmoid of a non-negative magnitude a, where v = a/4.
    function automatic longint sig_mag(input longint a);
        longint half;
        half = longint'(1) <<< (DATA_WIDTH-1);
        if (a < 4)
            return half/2 + (half*a)/16;
        else if (2*a < 19)
            return (half*5)/8 + (half*a)/32;
        else if (a < 20)
            return (half*27)/32 + (half*a)/128;
        else
            return half;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sig_entry(input longint x);
        longint half;
        longint v;
        half = longint'(1) <<< (DATA_WIDTH-1);
        if (x < 0)
            v = half - sig_mag(-x);
        else
            v = sig_mag(x);
        if (v > half-1)
            v = half-1;
        if (v < 0)
            v = 0;
        return DATA_WIDTH'(v);
    endfunction

    typedef logic [FULL_N-1:0][DATA_WIDTH-1:0] full_rom_t;

    function automatic full_rom_t build_full_rom();
        full_rom_t rom;
        longint    x;
        for (int i = 0; i < FULL_N; i++) begin
            x      = (i >= HALF_N) ? longint'(i - FULL_N) : longint'(i);
            rom[i] = sig_entry(x);
        end
        return rom;
    endfunction

    localparam full_rom_t FULL_ROM = build_full_rom();

    logic [WEIGHT_INT_WIDTH:0]   sign_region;
    logic                        in_range;
    logic [SIG_IN_WIDTH-1:0]     x_idx;
    logic [DATA_WIDTH-1:0]       slice;
    logic [DATA_WIDTH-1:0]       full_val;
    logic [DATA_WIDTH-1:0]       half_val;
    logic [DATA_WIDTH-1:0]       relu_val;
    logic [DATA_WIDTH-1:0]       act_val;
    logic                        unused_low;

    assign unused_low  = ^sum[DATA_WIDTH-WEIGHT_INT_WIDTH-1:0];
    assign sign_region = sum[S -: WEIGHT_INT_WIDTH+1];
    assign in_range    = (&sign_region) | ~(|sign_region);
    assign slice       = sum[TOP -: DATA_WIDTH];

    // Guard bits disagreeing with the sign means the index overflowed the ROM range.
    always_comb begin
        x_idx = sum[TOP -: SIG_IN_WIDTH];
        if (!in_range)
            x_idx = sum[S] ? X_MIN : X_MAX;
    end

    assign full_val = FULL_ROM[x_idx];

`ifdef ACT_SIG_HALF_ROM_EN
    typedef logic [HALF_N-1:0][DATA_WIDTH-1:0] half_rom_t;

    function automatic half_rom_t build_half_rom();
        half_rom_t rom;
        for (int i = 0; i < HALF_N; i++)
            rom[i] = sig_entry(longint'(i));
        return rom;
    endfunction

    localparam half_rom_t HALF_ROM = build_half_rom();

    logic                      x_neg;
    logic [SIG_IN_WIDTH-1:0]   neg_x;
    logic [SIG_IN_WIDTH-1:0]   mag;
    logic [SIG_IN_WIDTH-2:0]   half_addr;
    logic [DATA_WIDTH-1:0]     half_entry;

    assign x_neg = x_idx[SIG_IN_WIDTH-1];
    assign neg_x = ~x_idx + SIG_IN_WIDTH'(1);
    assign mag   = x_neg ? neg_x : x_idx;

    // Only the most negative index has a magnitude with the top bit set; clamp it.
    assign half_addr  = mag[SIG_IN_WIDTH-1] ? {(SIG_IN_WIDTH-1){1'b1}} : mag[SIG_IN_WIDTH-2:0];
    assign half_entry = HALF_ROM[half_addr];
    assign half_val   = x_neg ? (HALF_SCALE - half_entry) : half_entry;
`else
    assign half_val = full_val;
`endif

    always_comb begin
        relu_val = slice;
        if (sum[S])
            relu_val = '0;
        else if (|sum[S-1 -: WEIGHT_INT_WIDTH])
            relu_val = POS_MAX;
    end

    always_comb begin
        act_val = slice;
        case (act_sel)
            2'd0:    act_val = full_val;
            2'd1:    act_val = half_val;
            2'd2:    act_val = relu_val;
            default: act_val = slice;
        endcase
    end

    // ROM lookup is captured straight into the output register, so out holds between samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= act_val;
        end
    end

endmodule

// File: tb/tb_neuron_activation.sv
// Directed bench for neuron_activation: expected values queued at drive time, popped when out_valid rises.
module tb_neuron_activation;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [1:0]      act_sel;
    logic [2*DW-1:0] sum;
    logic [DW-1:0]   out;
    logic            out_valid;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp;

    neuron_activation #(
        .DATA_WIDTH(16),
        .WEIGHT_INT_WIDTH(1),
        .SIG_IN_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .act_sel(act_sel),
        .sum(sum),
        .out(out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // One cycle: drive at negedge, sample #1 after the following posedge.
    task automatic step(input string tag, input logic v, input logic [1:0] sel,
                        input logic [31:0] s, input logic [DW-1:0] e);
        logic [DW-1:0] popped;
        @(negedge clk);
        in_valid = v;
        act_sel  = sel;
        sum      = s;
        if (v)
            exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'(v));
        if (out_valid) begin
            chk({tag, "_qsz"}, 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                popped   = exp_q.pop_front();
                last_exp = popped;
                chk(tag, 32'(out), 32'(popped));
            end
        end else begin
            chk({tag, "_hold"}, 32'(out), 32'(last_exp));
        end
    endtask

    logic [1:0]    st_sel [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0]   st_sum [8] = '{32'h0400_0000, 32'h1000_0000, 32'hFFFF_FFFF, 32'h4000_0000,
                                  32'hF000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1234_5678};
    logic [DW-1:0] st_exp [8] = '{16'd18432, 16'd24576, 16'd0, 16'h8000,
                                  16'd8192, 16'd28672, 16'd8192, 16'h2468};

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        act_sel  = 2'd0;
        sum      = '0;
        last_exp = '0;
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        step("sig0_zero",  1'b1, 2'd0, 32'h0000_0000, 16'd16384);
        step("sig1_zero",  1'b1, 2'd1, 32'h0000_0000, 16'd16384);
        step("sig0_x1",    1'b1, 2'd0, 32'h0400_0000, 16'd18432);
        step("sig1_x1",    1'b1, 2'd1, 32'h0400_0000, 16'd18432);
        step("sig0_x4",    1'b1, 2'd0, 32'h1000_0000, 16'd24576);
        step("sig1_x4",    1'b1, 2'd1, 32'h1000_0000, 16'd24576);
        step("sig0_x8",    1'b1, 2'd0, 32'h2000_0000, 16'd28672);
        step("sig1_x8",    1'b1, 2'd1, 32'h2000_0000, 16'd28672);
        step("sig0_xm4",   1'b1, 2'd0, 32'hF000_0000, 16'd8192);
        step("sig1_xm4",   1'b1, 2'd1, 32'hF000_0000, 16'd8192);
        step("sig0_satp",  1'b1, 2'd0, 32'h4000_0000, 16'd31488);
        step("sig1_satp",  1'b1, 2'd1, 32'h4000_0000, 16'd31488);
        step("sig0_satn",  1'b1, 2'd0, 32'h8000_0000, 16'd1024);
`ifdef ACT_SIG_HALF_ROM_EN
        step("sig1_satn",  1'b1, 2'd1, 32'h8000_0000, 16'd1280);
`else
        step("sig1_satn",  1'b1, 2'd1, 32'h8000_0000, 16'd1024);
`endif
        step("relu_pos",   1'b1, 2'd2, 32'h1000_0000, 16'd8192);
        step("relu_neg",   1'b1, 2'd2, 32'hFFFF_FFFF, 16'd0);
        step("relu_sat",   1'b1, 2'd2, 32'h4000_0000, 16'd32767);
        step("pass_wrap",  1'b1, 2'd3, 32'h4000_0000, 16'h8000);
        step("idle",       1'b0, 2'd2, 32'hFFFF_FFFF, 16'd0);

        for (int i = 0; i < 8; i++)
            step($sformatf("stream%0d", i), 1'b1, st_sel[i], st_sum[i], st_exp[i]);

        // Reset lands between driving a sample and the edge that would capture it.
        @(negedge clk);
        in_valid = 1'b1;
        act_sel  = 2'd2;
        sum      = 32'h1000_0000;
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_vld", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(out), 32'd0);
        chk("rst_hold_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        last_exp = '0;
        chk("rst_q_empty", 32'(exp_q.size()), 32'd0);

        step("post_rst",      1'b1, 2'd0, 32'h1000_0000, 16'd24576);
        step("post_rst_idle", 1'b0, 2'd0, 32'h0000_0000, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
